usb_cmd_rx: RTL

USB_CMD_RX -- requirements
Module: usb_cmd_rx

---
 rtl/usb_cmd_rx_pkg.sv | 27 ++
 rtl/usb_cmd_rx_if.sv | 12 +
 rtl/ft245_rd_fsm.sv | 88 ++++++++
 rtl/usb_cmd_rx.sv | 106 ++++++++++
 4 files changed

// File: rtl/usb_cmd_rx_pkg.sv
// Shared definitions for the FT245 command receiver: command codes and read FSM states.
package usb_cmd_rx_pkg;

    localparam logic [7:0] CMD_CLEAR    = 8'd1;
    localparam logic [7:0] CMD_ADRCLR   = 8'd2;
    localparam logic [7:0] CMD_MEAS     = 8'd3;
    localparam logic [7:0] CMD_RDINIT   = 8'd4;
    localparam logic [7:0] CMD_XFER     = 8'd5;
    localparam logic [7:0] CMD_IDLE     = 8'd6;
    localparam logic [7:0] CMD_NORMAL   = 8'd7;
    localparam logic [7:0] CMD_LEN      = 8'd8;
    localparam logic [7:0] CMD_THR_UP32 = 8'd16;
    localparam logic [7:0] CMD_THR_DN32 = 8'd17;
    localparam logic [7:0] CMD_THR_UP4  = 8'd18;
    localparam logic [7:0] CMD_THR_DN4  = 8'd19;

    typedef enum logic [1:0] {
        IDLE,
        RDLOW,
        RECOV
    } rd_state_t;

    function automatic logic is_thr_cmd(input logic [7:0] code);
        return (code >= CMD_THR_UP32) && (code <= CMD_THR_DN4);
    endfunction

endpackage

// File: rtl/usb_cmd_rx_if.sv
// FT245 read-side bus: the reader (master) drives RD#, the FIFO side (slave) drives the rest.
interface usb_cmd_rx_if;

    logic       rxf_n;
    logic [7:0] usbd;
    logic       wr_active;
    logic       rd_n;

    modport master (output rd_n, input rxf_n, usbd, wr_active);
    modport slave  (input rd_n, output rxf_n, usbd, wr_active);

endinterface

// File: rtl/ft245_rd_fsm.sv
// FT245 read strobe sequencer: RD# low for RD_LOW_CYC cycles, sample, then RD_HIGH_CYC recovery.
module ft245_rd_fsm
    import usb_cmd_rx_pkg::*;
#(
    parameter int RD_LOW_CYC  = 5,
    parameter int RD_HIGH_CYC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    usb_cmd_rx_if.master       bus,
    output logic [7:0]         o_byte,
    output logic               o_valid
);

    localparam logic [7:0] LOW_LAST  = 8'(RD_LOW_CYC - 1);
    localparam logic [7:0] HIGH_LAST = 8'(RD_HIGH_CYC - 1);

    rd_state_t  r_state;
    rd_state_t  w_next_state;
    logic [7:0] r_cnt;
    logic [7:0] w_next_cnt;
    logic       w_sample;
    logic       w_start;
    logic       r_armed;
    logic       r_rd_n;
    logic       r_valid;
    logic [7:0] r_byte;

    // r_armed holds off the first read until the second edge after reset release
    assign w_start = r_armed && !bus.rxf_n && !bus.wr_active;

    // The last recovery edge doubles as the idle check, so RD# stays high exactly RD_HIGH_CYC cycles
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 8'd1;
        w_sample     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_cnt = 8'd0;
                if (w_start) begin
                    w_next_state = RDLOW;
                end
            end
            RDLOW: begin
                if (r_cnt == LOW_LAST) begin
                    w_next_state = RECOV;
                    w_next_cnt   = 8'd0;
                    w_sample     = 1'b1;
                end
            end
            RECOV: begin
                if (r_cnt == HIGH_LAST) begin
                    w_next_cnt   = 8'd0;
                    w_next_state = w_start ? RDLOW : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_armed <= 1'b0;
            r_rd_n  <= 1'b1;
            r_valid <= 1'b0;
            r_byte  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_armed <= 1'b1;
            r_rd_n  <= (w_next_state != RDLOW);
            r_valid <= w_sample;
            if (w_sample) begin
                r_byte <= bus.usbd;
            end
        end
    end

    assign bus.rd_n = r_rd_n;
    assign o_byte   = r_byte;
    assign o_valid  = r_valid;

endmodule

// File: rtl/usb_cmd_rx.sv
// FT245 command receiver: reads bytes, decodes mode commands and the WLLD threshold.
// Threshold commands 16-19 and the WLLD reload on CLEAR exist only with USB_CMD_THR_EN defined.
module usb_cmd_rx
    import usb_cmd_rx_pkg::*;
#(
    parameter int RD_LOW_CYC  = 5,
    parameter int RD_HIGH_CYC = 2,
    parameter int WLLD_INIT   = 540
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        RXF,
    input  logic [7:0]  USBD,
    input  logic        WR_ACTIVE,
    output logic        RD,
    output logic [7:0]  CMD,
    output logic        CMD_STB,
    output logic [9:0]  WLLD,
    output logic [15:0] RXCNT
);

    localparam logic [9:0] WLLD_RST = 10'(WLLD_INIT);

    usb_cmd_rx_if w_bus ();

    logic [7:0]  w_byte;
    logic        w_valid;
    logic        w_thr;
    logic [7:0]  r_cmd;
    logic        r_cmd_stb;
    logic [15:0] r_rxcnt;

    assign w_bus.rxf_n     = RXF;
    assign w_bus.usbd      = USBD;
    assign w_bus.wr_active = WR_ACTIVE;
    assign RD              = w_bus.rd_n;

    ft245_rd_fsm #(
        .RD_LOW_CYC  (RD_LOW_CYC),
        .RD_HIGH_CYC (RD_HIGH_CYC)
    ) u_rd_fsm (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .bus     (w_bus),
        .o_byte  (w_byte),
        .o_valid (w_valid)
    );

`ifdef USB_CMD_THR_EN
    logic [9:0]  r_wlld;
    logic [10:0] w_up32;
    logic [10:0] w_dn32;
    logic [10:0] w_up4;
    logic [10:0] w_dn4;

    // Bit 10 of each 11-bit result flags overflow past 1023 or borrow below 0
    assign w_up32 = {1'b0, r_wlld} + 11'd32;
    assign w_dn32 = {1'b0, r_wlld} - 11'd32;
    assign w_up4  = {1'b0, r_wlld} + 11'd4;
    assign w_dn4  = {1'b0, r_wlld} - 11'd4;
    assign w_thr  = is_thr_cmd(w_byte);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wlld <= WLLD_RST;
        end else if (w_valid) begin
            case (w_byte)
                CMD_THR_UP32: r_wlld <= w_up32[10] ? 10'd1023 : w_up32[9:0];
                CMD_THR_DN32: r_wlld <= w_dn32[10] ? 10'd0    : w_dn32[9:0];
                CMD_THR_UP4:  r_wlld <= w_up4[10]  ? 10'd1023 : w_up4[9:0];
                CMD_THR_DN4:  r_wlld <= w_dn4[10]  ? 10'd0    : w_dn4[9:0];
                CMD_CLEAR:    r_wlld <= WLLD_RST;
                default:      r_wlld <= r_wlld;
            endcase
        end
    end

    assign WLLD = r_wlld;
`else
    assign w_thr = 1'b0;
    assign WLLD  = WLLD_RST;
`endif

    // Every completed read is counted; zero and threshold bytes never touch CMD
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cmd     <= 8'd0;
            r_cmd_stb <= 1'b0;
            r_rxcnt   <= 16'd0;
        end else begin
            r_cmd_stb <= 1'b0;
            if (w_valid) begin
                r_rxcnt <= r_rxcnt + 16'd1;
                if ((w_byte != 8'd0) && !w_thr) begin
                    r_cmd     <= w_byte;
                    r_cmd_stb <= 1'b1;
                end
            end
        end
    end

    assign CMD     = r_cmd;
    assign CMD_STB = r_cmd_stb;
    assign RXCNT   = r_rxcnt;

endmodule
